// File: rtl/wave_playback_reader.sv
// ============================================================================
// wave_playback_reader
//   Wave channel read side: frequency timer, sample fetch, volume, length.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module wave_playback_reader #(
  parameter int FREQ_W = 11,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              tick,
  input  logic              len_tick,
  input  logic              dac_en,
  input  logic              trigger,
  input  logic [FREQ_W-1:0] freq,
  input  logic              len_en,
  input  logic              len_load,
  input  logic [LEN_W-1:0]  len_data,
  input  logic [1:0]        vol_code,
  input  logic [7:0]        ram_dout,
  output logic [3:0]        ram_addr,
  output logic              ram_rd,
  output logic [3:0]        sample,
  output logic [4:0]        pos,
  output logic              active
);

  localparam logic [FREQ_W-1:0] c_timer_max = '1;
  localparam logic [FREQ_W-1:0] c_timer_one = {{(FREQ_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W:0]    c_len_full  = {1'b1, {LEN_W{1'b0}}};
  localparam logic [LEN_W:0]    c_len_one   = {{LEN_W{1'b0}}, 1'b1};

  logic [FREQ_W-1:0] timer_q, timer_d;
  logic [4:0]        pos_q, pos_d;
  logic [7:0]        buf_q, buf_d;
  logic [LEN_W:0]    len_q, len_d;
  logic              active_q, active_d;
  logic              ram_rd_q, ram_rd_d;
  logic              rd_pending_q, rd_pending_d;

  logic              w_step;
  logic              w_len_dec;
  logic [3:0]        w_nibble;

  assign w_step = tick & active_q & (timer_q == c_timer_max);
  // Load and trigger both take priority over a length clock in the same cycle.
  assign w_len_dec = len_tick & len_en & (len_q != '0) & ~len_load & ~trigger;

  always_comb begin
    timer_d      = timer_q;
    pos_d        = pos_q;
    buf_d        = buf_q;
    len_d        = len_q;
    active_d     = active_q;
    ram_rd_d     = 1'b0;
    rd_pending_d = ram_rd_q;

    if (trigger) begin
      timer_d = freq;
      pos_d   = 5'd0;
    end else if (w_step) begin
      timer_d  = freq;
      pos_d    = pos_q + 5'd1;
      ram_rd_d = 1'b1;
    end else if (tick && active_q) begin
      timer_d = timer_q + c_timer_one;
    end

    // Read data arrives the cycle after the strobe is seen by the RAM.
    if (rd_pending_q) begin
      buf_d = ram_dout;
    end

    if (len_load) begin
      len_d = c_len_full - {1'b0, len_data};
    end else if (trigger && dac_en && (len_q == '0)) begin
      len_d = c_len_full;
    end else if (w_len_dec) begin
      len_d = len_q - c_len_one;
    end

    if (!dac_en) begin
      active_d = 1'b0;
    end else if (trigger) begin
      active_d = 1'b1;
    end else if (w_len_dec && (len_q == c_len_one)) begin
      active_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      timer_q      <= '0;
      pos_q        <= 5'd0;
      buf_q        <= 8'h00;
      len_q        <= '0;
      active_q     <= 1'b0;
      ram_rd_q     <= 1'b0;
      rd_pending_q <= 1'b0;
    end else begin
      timer_q      <= timer_d;
      pos_q        <= pos_d;
      buf_q        <= buf_d;
      len_q        <= len_d;
      active_q     <= active_d;
      ram_rd_q     <= ram_rd_d;
      rd_pending_q <= rd_pending_d;
    end
  end

  assign w_nibble = pos_q[0] ? buf_q[3:0] : buf_q[7:4];

  always_comb begin
    sample = 4'd0;
    if (active_q) begin
      case (vol_code)
        2'd0:    sample = 4'd0;
        2'd1:    sample = w_nibble;
        2'd2:    sample = w_nibble >> 1;
        default: sample = w_nibble >> 2;
      endcase
    end
  end

  assign ram_addr = pos_q[4:1];
  assign ram_rd   = ram_rd_q;
  assign pos      = pos_q;
  assign active   = active_q;

endmodule

`default_nettype wire

// File: tb/tb_wave_playback_reader.sv
// ============================================================================
// tb_wave_playback_reader
//   Directed, table-driven bench for wave_playback_reader with a RAM model.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_wave_playback_reader;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        tick = 1'b0;
  logic        len_tick = 1'b0;
  logic        dac_en = 1'b0;
  logic        trigger = 1'b0;
  logic [10:0] freq = 11'd0;
  logic        len_en = 1'b0;
  logic        len_load = 1'b0;
  logic [7:0]  len_data = 8'd0;
  logic [1:0]  vol_code = 2'd0;
  logic [7:0]  ram_dout = 8'd0;
  logic [3:0]  ram_addr;
  logic        ram_rd;
  logic [3:0]  sample;
  logic [4:0]  pos;
  logic        active;

  logic [7:0]  mem [16];
  int          rd_count = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [1:0] vol;
    logic [3:0] exp_sample;
  } vol_vec_t;

  vol_vec_t vol_tab [4];

  wave_playback_reader #(.FREQ_W(11), .LEN_W(8)) dut (
    .clk(clk), .n_reset(n_reset), .tick(tick), .len_tick(len_tick),
    .dac_en(dac_en), .trigger(trigger), .freq(freq), .len_en(len_en),
    .len_load(len_load), .len_data(len_data), .vol_code(vol_code),
    .ram_dout(ram_dout), .ram_addr(ram_addr), .ram_rd(ram_rd),
    .sample(sample), .pos(pos), .active(active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_rd) begin
      ram_dout <= mem[ram_addr];
      rd_count <= rd_count + 1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    cyc();
    trigger = 1'b0;
  endtask

  initial begin
    int p;
    int rd_snap;

    vol_tab[0] = '{2'd0, 4'h0};
    vol_tab[1] = '{2'd1, 4'hF};
    vol_tab[2] = '{2'd2, 4'h7};
    vol_tab[3] = '{2'd3, 4'h3};
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    // Reset state
    #2;
    cyc();
    cyc();
    check("rst_active", active, 0);
    check("rst_pos", pos, 0);
    check("rst_ram_rd", ram_rd, 0);
    check("rst_sample", sample, 0);
    n_reset = 1'b1;
    cyc();

    // First fetch
    mem[0]   = 8'hAB;
    vol_code = 2'd1;
    dac_en   = 1'b1;
    freq     = 11'h7FE;
    pulse_trigger();
    check("trig_active", active, 1);
    check("trig_pos", pos, 0);
    check("trig_stale_sample", sample, 0);
    pulse_tick();
    check("first_tick_no_rd", ram_rd, 0);
    cyc();
    pulse_tick();
    check("step_ram_rd", ram_rd, 1);
    check("step_addr", ram_addr, 0);
    check("step_pos", pos, 1);
    cyc();
    check("rd_one_clk", ram_rd, 0);
    cyc();
    check("first_sample", sample, 4'hB);

    // 64 steps across the full buffer, wrapping pos
    for (int i = 0; i < 16; i++) mem[i] = 8'(i * 8'h11);
    freq = 11'h7FF;
    pulse_trigger();
    for (int i = 0; i < 64; i++) begin
      p = (i + 1) % 32;
      pulse_tick();
      check("run_ram_rd", ram_rd, 1);
      check("run_pos", pos, p);
      check("run_addr", ram_addr, p >> 1);
      cyc();
      cyc();
      check("run_sample", sample, p >> 1);
      cyc();
    end

    // Volume sweep on nibble 0xF
    for (int i = 0; i < 16; i++) mem[i] = 8'hFF;
    pulse_tick();
    cyc();
    cyc();
    for (int i = 0; i < 4; i++) begin
      vol_code = vol_tab[i].vol;
      #1;
      check("vol_sweep", sample, vol_tab[i].exp_sample);
    end
    vol_code = 2'd1;

    // Length expiry
    len_data = 8'hFE;
    len_load = 1'b1;
    cyc();
    len_load = 1'b0;
    len_en   = 1'b1;
    pulse_trigger();
    check("len_active_after_trig", active, 1);
    len_tick = 1'b1;
    cyc();
    check("len_tick1_active", active, 1);
    cyc();
    check("len_tick2_active", active, 0);
    check("len_tick2_sample", sample, 0);
    cyc();
    len_tick = 1'b0;
    check("len_tick3_active", active, 0);
    rd_snap = rd_count;
    for (int i = 0; i < 3; i++) begin
      pulse_tick();
      cyc();
    end
    check("len_no_rd", rd_count, rd_snap);
    len_en = 1'b0;

    // Trigger coincident with a step
    freq = 11'h7FF;
    pulse_trigger();
    pulse_tick();
    check("pre_pos", pos, 1);
    cyc();
    cyc();
    tick    = 1'b1;
    trigger = 1'b1;
    cyc();
    tick    = 1'b0;
    trigger = 1'b0;
    check("trigstep_no_rd", ram_rd, 0);
    check("trigstep_pos", pos, 0);
    check("trigstep_active", active, 1);

    // dac_en low: active clears, pos retained, trigger cannot restart
    pulse_tick();
    cyc();
    cyc();
    dac_en = 1'b0;
    cyc();
    check("dacoff_active", active, 0);
    check("dacoff_pos_kept", pos, 1);
    tick    = 1'b1;
    trigger = 1'b1;
    cyc();
    tick    = 1'b0;
    trigger = 1'b0;
    check("dacoff_trig_active", active, 0);
    check("dacoff_trig_pos", pos, 0);
    check("dacoff_trig_no_rd", ram_rd, 0);

    // Reset the clk after ram_rd discards the pending read
    mem[0] = 8'hAB;
    dac_en = 1'b1;
    pulse_trigger();
    cyc();
    cyc();
    cyc();
    pulse_tick();
    check("rstfetch_ram_rd", ram_rd, 1);
    n_reset = 1'b0;
    cyc();
    check("rstfetch_active", active, 0);
    check("rstfetch_pos", pos, 0);
    check("rstfetch_ram_rd_clr", ram_rd, 0);
    check("rstfetch_sample", sample, 0);
    n_reset = 1'b1;
    cyc();
    cyc();
    pulse_trigger();
    check("rstfetch_retrig_active", active, 1);
    check("rstfetch_buffer_clear", sample, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wave_playback_reader.md
Name: wave_playback_reader

Overview:
- Read side of the wave-channel sample RAM (channel 3).
- Sequences through the 32 4-bit samples packed in 16 bytes and fetches each byte over the RAM read port.
- Applies the volume shift and drives the 4-bit sample to the channel DAC.
- Owns the channel frequency timer, length counter and active flag; CPU-side RAM writes and bus arbitration are outside this block.

Parameters:
- FREQ_W, 11, width of the frequency register and timer.
- LEN_W, 8, width of the length load value; the internal length counter is LEN_W+1 bits.

Ports:
- clk  input  1  system clock.
- n_reset  input  1  synchronous active-low reset.
- tick  input  1  timer clock enable, one clk wide (2 MHz rate).
- len_tick  input  1  length clock enable from the frame sequencer, one clk wide.
- dac_en  input  1  channel DAC power (NR30 bit 7).
- trigger  input  1  channel restart pulse, one clk wide.
- freq  input  FREQ_W  frequency register.
- len_en  input  1  length counter enable.
- len_load  input  1  length load strobe, one clk wide.
- len_data  input  LEN_W  length load value.
- vol_code  input  2  output level: 0 = mute, 1 = 100%, 2 = 50%, 3 = 25%.
- ram_dout  input  8  RAM read data, valid the clk after ram_rd.
- ram_addr  output  4  RAM byte address, equal to pos[4:1].
- ram_rd  output  1  RAM read strobe, one clk wide.
- sample  output  4  volume-shifted sample.
- pos  output  5  current sample index.
- active  output  1  channel running.

Behaviour:
- Reset values (n_reset low at a clk edge): timer=0, pos=0, sample buffer=0x00, len_cnt=0, active=0, ram_rd=0, rd_pending=0, sample=0. Reset mid-fetch discards the pending read.
- Frequency timer:
  - On tick while active: timer increments.
  - On timer == 2^FREQ_W-1 with tick, the step event fires: timer reloads with freq, pos increments modulo 32 (31 -> 0), and ram_rd is asserted the same clk with ram_addr = the new pos[4:1].
- Fetch:
  - rd_pending is set with ram_rd.
  - On the next clk, ram_dout is latched into the sample buffer and rd_pending clears.
  - Fetch latency is 2 clks from the step event to sample update.
  - A step requires at least 2 clks between ticks; back-to-back fetches never overlap.
- Nibble select:
  - pos even -> buffer[7:4]; pos odd -> buffer[3:0].
  - pos and the buffer are both registered; sample is combinational from them through the volume shift.
  - A pos change before the new byte lands selects a nibble of the old buffer for one clk. This is accepted.
- Volume shift: code 0 -> 0; code 1 -> nibble; code 2 -> nibble>>1; code 3 -> nibble>>2. sample=0 whenever active=0.
- Trigger:
  - If dac_en=1: timer<=freq, pos<=0, active<=1, and if len_cnt==0 then len_cnt<=2^LEN_W.
  - The sample buffer is not reloaded. The first fetched sample is index 1; index 0 is played from the stale buffer until the first step.
  - If dac_en=0: active stays 0; the timer and pos still reload.
- Trigger coincident with a step event: trigger wins. No ram_rd is issued and pos=0.
- Trigger coincident with rd_pending: the pending latch still completes.
- Length:
  - len_load: len_cnt<=2^LEN_W - len_data.
  - On len_tick with len_en=1 and len_cnt!=0: decrement. Reaching 0 clears active the same clk.
  - len_load and len_tick in the same clk: load wins.
  - Trigger and len_tick in the same clk: trigger reload first, then no decrement that clk.
- dac_en=0 clears active on the next clk edge regardless of other inputs; pos and the buffer are retained.
- Arithmetic: all counters wrap silently within their width. freq=2^FREQ_W-1 gives a step on every tick.

Test Plan:
- Reset then trigger with dac_en=1, freq=0x7FE, vol_code=1, RAM byte0=0xAB -> step after 2 ticks; ram_rd with ram_addr=0, pos=1; 2 clks later sample=0xB.
- Run 64 steps with RAM bytes 0x00..0xFF pattern (byte n = n*0x11) -> pos wraps 31->0; ram_addr sequence 0,1,1,2,...,15,0; sample matches the nibble for every index.
- vol_code sweep 0..3 with nibble 0xF -> sample 0x0, 0xF, 0x7, 0x3.
- len_load 0xFE, len_en=1, trigger, three len_ticks -> active falls on the 2nd len_tick; sample=0 thereafter; ram_rd never asserts again.
- Trigger in the same clk as a step event, and trigger with dac_en=0 -> no ram_rd, pos=0; with dac_en=0, active stays 0.
- n_reset asserted the clk after ram_rd -> buffer stays 0x00, active=0, all outputs at reset values.
